// File: rtl/audio_capture_pkg.sv
// Shared configuration for the audio capture path: sample width, clock-loss
// timeout, pair FIFO depth and the stereo pair type.
package configPackage;

    localparam int AUDIO_SAMPLE_BITS    = 16;
    localparam int AUDIO_TIMEOUT_CYCLES = 4096;
    localparam int AUDIO_FIFO_DEPTH     = 4;

    typedef struct packed {
        logic [AUDIO_SAMPLE_BITS-1:0] left;
        logic [AUDIO_SAMPLE_BITS-1:0] right;
    } audio_pair_t;

endpackage

// File: rtl/audio_capture_fifo.sv
// audio_fifo: small synchronous FIFO of stereo pairs. A push to a full FIFO is
// accepted only when a pop happens in the same cycle.
module audio_fifo
    import configPackage::*;
#(
    parameter int DEPTH = AUDIO_FIFO_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  audio_pair_t pushData_i,
    input  logic        pop_i,
    output audio_pair_t popData_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    audio_pair_t        mem_q [DEPTH];
    logic [PTR_W-1:0]   wrPtr_q;
    logic [PTR_W-1:0]   rdPtr_q;
    logic [PTR_W:0]     count_q;
    logic               doPush;
    logic               doPop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
    assign doPop     = pop_i & ~empty_o;
    assign doPush    = push_i & (~full_o | doPop);
    assign popData_o = mem_q[rdPtr_q];

    // Storage is cleared on reset so the head reads as zero before the first pair.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= pushData_i;
                wrPtr_q        <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q <= count_q + (PTR_W+1)'(doPush) - (PTR_W+1)'(doPop);
        end
    end

endmodule

// File: rtl/audio_capture.sv
// audio_capture: I2S receiver for the console audio pins, pairing left/right words in the clk domain.
// Define AUDIO_FIFO_EN to buffer pairs in a valid/ready FIFO; otherwise sampleValid is a one-cycle pulse.
module audio_capture
    import configPackage::*;
#(
    parameter int SAMPLE_BITS    = AUDIO_SAMPLE_BITS,
    parameter int TIMEOUT_CYCLES = AUDIO_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   BCLK,
    input  logic                   LRCK,
    input  logic                   SDAT,
    output logic [SAMPLE_BITS-1:0] sampleL,
    output logic [SAMPLE_BITS-1:0] sampleR,
    output logic                   sampleValid,
    input  logic                   sampleReady,
    output logic                   active,
    output logic                   overflow
);

    localparam int                CNT_W   = $clog2(SAMPLE_BITS + 1);
    localparam int                WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SAMPLE_BITS);
    localparam logic [WD_W-1:0]   WD_MAX  = WD_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]             bclkSync_q;
    logic [1:0]             lrSync_q, sdSync_q;
    logic                   rise, lrBit, sdBit, expire;

    logic                   lrPrev_q, lrPrev_d;
    logic                   locked_q, locked_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SAMPLE_BITS-1:0] shift_q, shift_d, wordNext;
    logic [SAMPLE_BITS-1:0] leftHold_q, leftHold_d;
    logic                   leftValid_q, leftValid_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   pairValid_q, pairValid_d;
    logic [SAMPLE_BITS-1:0] pairL_q, pairL_d, pairR_q, pairR_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            bclkSync_q <= '0;
            lrSync_q   <= '0;
            sdSync_q   <= '0;
        end else begin
            bclkSync_q <= {bclkSync_q[1:0], BCLK};
            lrSync_q   <= {lrSync_q[0], LRCK};
            sdSync_q   <= {sdSync_q[0], SDAT};
        end
    end

    assign rise   = bclkSync_q[1] & ~bclkSync_q[2];
    assign lrBit  = lrSync_q[1];
    assign sdBit  = sdSync_q[1];
    assign expire = (wd_q == WD_MAX);
    assign active = locked_q & ~expire;

    // Bits land left-aligned at position SAMPLE_BITS-1-cnt, so short words are zero padded.
    always_comb begin
        wordNext    = shift_q;
        for (int i = 0; i < SAMPLE_BITS; i++) begin
            if (cnt_q == CNT_W'(SAMPLE_BITS - 1 - i)) begin
                wordNext[i] = sdBit;
            end
        end
        lrPrev_d    = lrPrev_q;
        locked_d    = locked_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        leftHold_d  = leftHold_q;
        leftValid_d = leftValid_q;
        pairValid_d = 1'b0;
        pairL_d     = pairL_q;
        pairR_d     = pairR_q;
        wd_d        = rise ? '0 : (expire ? wd_q : wd_q + WD_W'(1));

        if (expire) begin
            locked_d    = 1'b0;
            cnt_d       = '0;
            shift_d     = '0;
            leftHold_d  = '0;
            leftValid_d = 1'b0;
        end else if (rise) begin
            lrPrev_d = lrBit;
            if (lrBit != lrPrev_q) begin
                // Change edge: its bit closes the previous word; the first one only locks.
                locked_d = 1'b1;
                cnt_d    = '0;
                shift_d  = '0;
                if (locked_q && !lrPrev_q) begin
                    leftHold_d  = wordNext;
                    leftValid_d = 1'b1;
                end else if (locked_q && leftValid_q) begin
                    pairValid_d = 1'b1;
                    pairL_d     = leftHold_q;
                    pairR_d     = wordNext;
                    leftValid_d = 1'b0;
                end
            end else begin
                shift_d = wordNext;
                cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lrPrev_q    <= 1'b0;
            locked_q    <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            leftHold_q  <= '0;
            leftValid_q <= 1'b0;
            wd_q        <= '0;
            pairValid_q <= 1'b0;
            pairL_q     <= '0;
            pairR_q     <= '0;
        end else begin
            lrPrev_q    <= lrPrev_d;
            locked_q    <= locked_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            leftHold_q  <= leftHold_d;
            leftValid_q <= leftValid_d;
            wd_q        <= wd_d;
            pairValid_q <= pairValid_d;
            pairL_q     <= pairL_d;
            pairR_q     <= pairR_d;
        end
    end

`ifdef AUDIO_FIFO_EN
    audio_pair_t pushPair, popPair;
    logic        fifoFull, fifoEmpty, popFire;
    logic        overflow_q;

    assign pushPair = {pairL_q, pairR_q};
    assign popFire  = ~fifoEmpty & sampleReady;

    audio_fifo #(.DEPTH(AUDIO_FIFO_DEPTH)) u_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .push_i     (pairValid_q),
        .pushData_i (pushPair),
        .pop_i      (popFire),
        .popData_o  (popPair),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (pairValid_q && fifoFull && !popFire) begin
            overflow_q <= 1'b1;
        end
    end

    assign sampleL     = popPair.left;
    assign sampleR     = popPair.right;
    assign sampleValid = ~fifoEmpty;
    assign overflow    = overflow_q;
`else
    logic [SAMPLE_BITS-1:0] sampleL_q, sampleR_q;
    logic                   sampleValid_q;
    logic                   unusedReady;

    assign unusedReady = sampleReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            sampleL_q     <= '0;
            sampleR_q     <= '0;
            sampleValid_q <= 1'b0;
        end else begin
            sampleValid_q <= pairValid_q;
            if (pairValid_q) begin
                sampleL_q <= pairL_q;
                sampleR_q <= pairR_q;
            end
        end
    end

    assign sampleL     = sampleL_q;
    assign sampleR     = sampleR_q;
    assign sampleValid = sampleValid_q;
    assign overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_audio_capture.sv
// Directed testbench for audio_capture: I2S framing, word length handling,
// clock-loss timeout, mid-stream reset and (with AUDIO_FIFO_EN) pair buffering.
module tb_audio_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        BCLK = 1'b0;
    logic        LRCK = 1'b0;
    logic        SDAT = 1'b0;
    logic        sampleReady = 1'b0;
    logic [15:0] sampleL, sampleR;
    logic        sampleValid, active, overflow;

    int          checkCount = 0;
    int          errorCount = 0;
    logic        pendingBit = 1'b0;
    logic [15:0] gotL[$];
    logic [15:0] gotR[$];
    int          gotCycle[$];
    int          cycleCount = 0;
    int          validRises = 0;
    logic        prevValid = 1'b0;
    logic        acceptPair;
    int          base, rises0;

    audio_capture dut (
        .clk         (clk),
        .rst         (rst),
        .BCLK        (BCLK),
        .LRCK        (LRCK),
        .SDAT        (SDAT),
        .sampleL     (sampleL),
        .sampleR     (sampleR),
        .sampleValid (sampleValid),
        .sampleReady (sampleReady),
        .active      (active),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

`ifdef AUDIO_FIFO_EN
    assign acceptPair = sampleValid & sampleReady;
`else
    assign acceptPair = sampleValid;
`endif

    // Pair monitor: records every accepted pair with its cycle stamp.
    always @(negedge clk) begin
        cycleCount++;
        if (sampleValid && !prevValid) validRises++;
        prevValid = sampleValid;
        if (acceptPair) begin
            gotL.push_back(sampleL);
            gotR.push_back(sampleR);
            gotCycle.push_back(cycleCount);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish (got running, expected done)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkPair(input string tag, input int idx, input logic [15:0] l, input logic [15:0] r);
        if (idx < gotL.size()) begin
            checkOutput({tag, "_L"}, 32'(gotL[idx]), 32'(l));
            checkOutput({tag, "_R"}, 32'(gotR[idx]), 32'(r));
        end else begin
            checkOutput({tag, "_present"}, gotL.size(), idx + 1);
        end
    endtask

    // One BCLK period of 16 clk: data changes while BCLK is low.
    task automatic applyStimulus(input logic lr, input logic sd);
        @(negedge clk);
        BCLK = 1'b0;
        LRCK = lr;
        SDAT = sd;
        repeat (8) @(negedge clk);
        BCLK = 1'b1;
        repeat (7) @(negedge clk);
    endtask

    // Rise k=0 carries the previous word's LSB; rises 1..n-1 carry this word MSB first.
    task automatic sendBits(input logic lr, input logic [31:0] word, input int nbits,
                            input int kFrom, input int kTo);
        for (int k = kFrom; k < kTo; k++) begin
            if (k == 0) applyStimulus(lr, pendingBit);
            else        applyStimulus(lr, word[nbits - k]);
        end
        if (kTo == nbits) pendingBit = word[0];
    endtask

    task automatic sendWord(input logic lr, input logic [31:0] word, input int nbits);
        sendBits(lr, word, nbits, 0, nbits);
    endtask

    task automatic sendFrame(input logic [31:0] l, input logic [31:0] r, input int nbits);
        sendWord(1'b0, l, nbits);
        sendWord(1'b1, r, nbits);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic resetStream();
        BCLK = 1'b0;
        LRCK = 1'b0;
        SDAT = 1'b0;
        pendingBit = 1'b0;
        repeat (4) @(negedge clk);
        applyReset();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_sampleL"}, 32'(sampleL), 32'h0);
        checkOutput({tag, "_sampleR"}, 32'(sampleR), 32'h0);
        checkOutput({tag, "_sampleValid"}, 32'(sampleValid), 32'h0);
        checkOutput({tag, "_active"}, 32'(active), 32'h0);
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'h0);
    endtask

    initial begin
`ifdef AUDIO_FIFO_EN
        sampleReady = 1'b1;
`else
        sampleReady = 1'b0;
`endif
        resetStream();
        checkResetOutputs("reset");

        $display("[TB] basic framing 16-bit");
        base = gotL.size();
        rises0 = validRises;
        sendWord(1'b0, 32'h8001, 16);
        checkOutput("t1_active_prelock", 32'(active), 32'h0);
        sendWord(1'b1, 32'h7FFE, 16);
        checkOutput("t1_active_locked", 32'(active), 32'h1);
        sendFrame(32'h8001, 32'h7FFE, 16);
        checkOutput("t1_first_frame_dropped", gotL.size() - base, 0);
        sendWord(1'b0, 32'h8001, 16);
        checkOutput("t1_pairs_after_f2", gotL.size() - base, 1);
        sendWord(1'b1, 32'h7FFE, 16);
        sendWord(1'b0, 32'h0, 16);
        checkOutput("t1_pairs_after_f3", gotL.size() - base, 2);
        checkPair("t1_pair0", base, 16'h8001, 16'h7FFE);
        checkPair("t1_pair1", base + 1, 16'h8001, 16'h7FFE);
        checkOutput("t1_valid_pulses", validRises - rises0, gotL.size() - base);
        checkOutput("t1_overflow", 32'(overflow), 32'h0);

        $display("[TB] long words truncated");
        resetStream();
        base = gotL.size();
        sendFrame(32'h1234FF, 32'h5678AA, 24);
        sendFrame(32'h1234FF, 32'h5678AA, 24);
        sendWord(1'b0, 32'h0, 24);
        checkOutput("t2_pairs", gotL.size() - base, 1);
        checkPair("t2_pair", base, 16'h1234, 16'h5678);

        $display("[TB] short words padded");
        resetStream();
        base = gotL.size();
        sendFrame(32'hABC, 32'h123, 12);
        sendFrame(32'hABC, 32'h123, 12);
        sendWord(1'b0, 32'h0, 12);
        checkOutput("t3_pairs", gotL.size() - base, 1);
        checkPair("t3_pair", base, 16'hABC0, 16'h1230);

        $display("[TB] BCLK loss timeout");
        resetStream();
        base = gotL.size();
        sendFrame(32'hAAAA, 32'h5555, 16);
        sendFrame(32'hAAAA, 32'h5555, 16);
        sendWord(1'b0, 32'hAAAA, 16);
        checkOutput("t4_pairs_before_stop", gotL.size() - base, 1);
        sendBits(1'b1, 32'h5555, 16, 0, 9);
        repeat (4000) @(negedge clk);
        checkOutput("t4_active_before_expiry", 32'(active), 32'h1);
        repeat (300) @(negedge clk);
        checkOutput("t4_active_after_expiry", 32'(active), 32'h0);
        checkOutput("t4_no_pair_during_stop", gotL.size() - base, 1);
`ifndef AUDIO_FIFO_EN
        checkOutput("t4_sampleL_held", 32'(sampleL), 32'hAAAA);
`endif
        sendBits(1'b1, 32'h5555, 16, 9, 16);
        sendFrame(32'h1111, 32'h2222, 16);
        checkOutput("t4_active_relocked", 32'(active), 32'h1);
        sendFrame(32'h3333, 32'h4444, 16);
        sendWord(1'b0, 32'h0, 16);
        checkOutput("t4_pairs_total", gotL.size() - base, 3);
        checkPair("t4_pair_resume0", base + 1, 16'h1111, 16'h2222);
        checkPair("t4_pair_resume1", base + 2, 16'h3333, 16'h4444);

        $display("[TB] mid-stream reset");
        resetStream();
        base = gotL.size();
        sendFrame(32'h0101, 32'h0202, 16);
        sendFrame(32'h0101, 32'h0202, 16);
        sendWord(1'b0, 32'h0101, 16);
        sendBits(1'b1, 32'h0202, 16, 0, 6);
        checkOutput("t5_pairs_before_reset", gotL.size() - base, 1);
        applyReset();
        checkResetOutputs("t5_midreset");
        base = gotL.size();
        sendBits(1'b1, 32'h0202, 16, 6, 16);
        sendFrame(32'h0F0F, 32'hF0F0, 16);
        sendWord(1'b0, 32'h0, 16);
        checkOutput("t5_pairs_after_reset", gotL.size() - base, 1);
        checkPair("t5_pair", base, 16'h0F0F, 16'hF0F0);

`ifdef AUDIO_FIFO_EN
        $display("[TB] FIFO backpressure");
        resetStream();
        sampleReady = 1'b0;
        base = gotL.size();
        for (int k = 1; k <= 7; k++) begin
            sendFrame(32'h1000 + 32'(k), 32'h2000 + 32'(k), 16);
        end
        sendWord(1'b0, 32'h0, 16);
        checkOutput("t6_no_pop", gotL.size() - base, 0);
        checkOutput("t6_overflow", 32'(overflow), 32'h1);
        checkOutput("t6_valid_held", 32'(sampleValid), 32'h1);
        checkOutput("t6_head_L", 32'(sampleL), 32'h1002);
        checkOutput("t6_head_R", 32'(sampleR), 32'h2002);
        @(posedge clk);
        #1 sampleReady = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("t6_drained", gotL.size() - base, 4);
        for (int k = 0; k < 4; k++) begin
            checkPair($sformatf("t6_pair%0d", k), base + k, 16'h1002 + 16'(k), 16'h2002 + 16'(k));
        end
        if (gotCycle.size() >= base + 4) begin
            checkOutput("t6_consecutive", gotCycle[base + 3] - gotCycle[base], 3);
        end
        checkOutput("t6_empty", 32'(sampleValid), 32'h0);
        checkOutput("t6_overflow_sticky", 32'(overflow), 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
